// File: rtl/fir_tdm_pkg.sv
// ---------------------------------------------------------------------------
// fir_tdm_pkg
// Shared definitions for the TDM FIR tap buffer and the MAC stage that
// consumes its tap vectors.
//   clog2_min1()    : channel-index width helper, never returns 0
//   CHN_W           : channel-index width for the default channel count
//   trk_state_e     : lock state of the channel tracker
//   FIR_TAP_SLICE   : part-select of tap t inside a packed tap vector
//                     (tap 0 = newest sample in the low slice)
// ---------------------------------------------------------------------------
`ifndef FIR_TDM_PKG_SV
`define FIR_TDM_PKG_SV

// Part-select of tap t in a packed vector of w-bit samples.
`define FIR_TAP_SLICE(t, w) (t)*(w) +: (w)

package fir_tdm_pkg;

    // A single-channel system still needs a 1-bit channel field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CHN_DEF = 4;
    localparam int NUM_TAP_DEF = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int CHN_W       = clog2_min1(NUM_CHN_DEF);

    typedef enum logic {
        TRK_UNLOCKED = 1'b0,
        TRK_LOCKED   = 1'b1
    } trk_state_e;

endpackage

`endif

// File: rtl/fir_tdm_chn_tracker.sv
// ---------------------------------------------------------------------------
// fir_tdm_chn_tracker
// Follows the TDM channel slot of the incoming sample stream.
//   clk, rst      : clock, synchronous active-high reset
//   valid_i       : sample strobe
//   sync_i        : frame start marker, only meaningful with valid_i
//   flush_i       : drops lock and rewinds the slot pointer
//   accept_o      : current strobe is taken into the history (comb)
//   cur_chn_o     : channel the current strobe belongs to (comb)
//   err_o         : current strobe reveals sync misalignment (comb)
//   state_o       : lock state (debug view)
//   chn_ptr_o     : expected channel of the next strobe (debug view)
// ---------------------------------------------------------------------------
module fir_tdm_chn_tracker
    import fir_tdm_pkg::*;
#(
    parameter int NUM_CHN  = 4,
    parameter int CHN_BITS = clog2_min1(NUM_CHN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                sync_i,
    input  logic                flush_i,
    output logic                accept_o,
    output logic [CHN_BITS-1:0] cur_chn_o,
    output logic                err_o,
    output trk_state_e          state_o,
    output logic [CHN_BITS-1:0] chn_ptr_o
);

    localparam logic [CHN_BITS-1:0] LAST_CHN = CHN_BITS'(NUM_CHN - 1);

    trk_state_e          r_state;
    logic [CHN_BITS-1:0] r_chn_ptr;

    logic                w_live;
    logic                w_locked;
    logic                w_accept;
    logic [CHN_BITS-1:0] w_cur;
    logic                w_err;

    always_comb begin
        // Flush outranks a coincident strobe: the sample is simply lost.
        w_live   = valid_i & ~flush_i;
        w_locked = (r_state == TRK_LOCKED);
        // While unlocked only a sync strobe gets in; it establishes lock.
        w_accept = w_live & (w_locked | sync_i);
        w_cur    = sync_i ? '0 : r_chn_ptr;
        // Misalignment: sync in the wrong slot, or slot 0 reached without sync.
        // With a single channel the pointer is always 0, so every locked
        // strobe lacking sync is reported.
        w_err    = w_live & w_locked &
                   (sync_i ? (r_chn_ptr != '0) : (r_chn_ptr == '0));
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_state   <= TRK_UNLOCKED;
            r_chn_ptr <= '0;
        end else begin
            case (r_state)
                TRK_UNLOCKED: begin
                    if (w_accept) begin
                        r_state   <= TRK_LOCKED;
                        r_chn_ptr <= (w_cur == LAST_CHN) ? '0 : w_cur + CHN_BITS'(1);
                    end
                end
                TRK_LOCKED: begin
                    if (w_accept) begin
                        r_chn_ptr <= (w_cur == LAST_CHN) ? '0 : w_cur + CHN_BITS'(1);
                    end
                end
                default: begin
                    r_state   <= TRK_UNLOCKED;
                    r_chn_ptr <= '0;
                end
            endcase
        end
    end

    assign accept_o  = w_accept;
    assign cur_chn_o = w_cur;
    assign err_o     = w_err;
    assign state_o   = r_state;
    assign chn_ptr_o = r_chn_ptr;

endmodule

// File: rtl/fir_tdm_tap_buffer.sv
// ---------------------------------------------------------------------------
// fir_tdm_tap_buffer
// Per-channel FIR tap delay line fed by the TDM sample-strobe generator.
// Holds the last NUM_TAP samples of every channel and, one cycle after each
// accepted sample, presents that channel's full tap vector to the MAC stage.
//   clk, rst      : clock, synchronous active-high reset
//   valid_i       : sample strobe (no back-pressure, may be high every cycle)
//   sync_i        : frame start (channel 0), qualified by valid_i
//   data_i        : sample, captured when valid_i=1
//   flush_i       : clears histories and lock, wins over valid_i
//   tap_valid_o   : one-cycle pulse, tap vector valid
//   tap_chn_o     : channel of the tap vector
//   tap_data_o    : tap vector, low slice newest, top slice oldest
//   frame_done_o  : pulses with tap_valid_o for the last channel
//   sync_err_o    : one-cycle pulse, aligned with tap_valid_o
//
// Handshake: the interface is valid-only. Every accepted strobe produces
// exactly one tap_valid_o pulse on the following cycle; there is no ready
// and no stall. tap_chn_o/tap_data_o hold between pulses.
// ---------------------------------------------------------------------------
module fir_tdm_tap_buffer
    import fir_tdm_pkg::*;
#(
    parameter  int NUM_CHN  = 4,
    parameter  int NUM_TAP  = 8,
    parameter  int DATA_W   = 16,
    localparam int CHN_BITS = clog2_min1(NUM_CHN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic                      sync_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      flush_i,
    output logic                      tap_valid_o,
    output logic [CHN_BITS-1:0]       tap_chn_o,
    output logic [NUM_TAP*DATA_W-1:0] tap_data_o,
    output logic                      frame_done_o,
    output logic                      sync_err_o
);

    localparam logic [CHN_BITS-1:0] LAST_CHN = CHN_BITS'(NUM_CHN - 1);

    logic [DATA_W-1:0]         r_hist [NUM_CHN][NUM_TAP];
    logic                      r_tap_valid;
    logic [CHN_BITS-1:0]       r_tap_chn;
    logic [NUM_TAP*DATA_W-1:0] r_tap_data;
    logic                      r_frame_done;
    logic                      r_sync_err;

    logic                      w_accept;
    logic [CHN_BITS-1:0]       w_cur;
    logic                      w_err;
    trk_state_e                w_trk_state;
    logic [CHN_BITS-1:0]       w_chn_ptr;
    logic [DATA_W-1:0]         w_cur_hist [NUM_TAP];
    logic [NUM_TAP*DATA_W-1:0] w_next_vec;

    fir_tdm_chn_tracker #(
        .NUM_CHN  (NUM_CHN),
        .CHN_BITS (CHN_BITS)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .sync_i    (sync_i),
        .flush_i   (flush_i),
        .accept_o  (w_accept),
        .cur_chn_o (w_cur),
        .err_o     (w_err),
        .state_o   (w_trk_state),
        .chn_ptr_o (w_chn_ptr)
    );

    // History of the addressed channel, before this cycle's shift.
    always_comb begin
        for (int t = 0; t < NUM_TAP; t++) begin
            w_cur_hist[t] = '0;
        end
        for (int c = 0; c < NUM_CHN; c++) begin
            if (w_cur == CHN_BITS'(c)) begin
                for (int t = 0; t < NUM_TAP; t++) begin
                    w_cur_hist[t] = r_hist[c][t];
                end
            end
        end
    end

    // Post-shift tap vector: new sample in tap 0, everything else one older.
    always_comb begin
        w_next_vec = '0;
        w_next_vec[`FIR_TAP_SLICE(0, DATA_W)] = data_i;
        for (int t = 1; t < NUM_TAP; t++) begin
            w_next_vec[`FIR_TAP_SLICE(t, DATA_W)] = w_cur_hist[t-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                for (int t = 0; t < NUM_TAP; t++) begin
                    r_hist[c][t] <= '0;
                end
            end
            r_tap_valid  <= 1'b0;
            r_tap_chn    <= '0;
            r_tap_data   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_tap_valid  <= w_accept;
            r_frame_done <= w_accept & (w_cur == LAST_CHN);
            r_sync_err   <= w_err;
            if (w_accept) begin
                r_tap_chn  <= w_cur;
                r_tap_data <= w_next_vec;
                // Only the addressed channel shifts; the rest hold.
                for (int c = 0; c < NUM_CHN; c++) begin
                    if (w_cur == CHN_BITS'(c)) begin
                        r_hist[c][0] <= data_i;
                        for (int t = 1; t < NUM_TAP; t++) begin
                            r_hist[c][t] <= r_hist[c][t-1];
                        end
                    end
                end
            end
        end
    end

    assign tap_valid_o  = r_tap_valid;
    assign tap_chn_o    = r_tap_chn;
    assign tap_data_o   = r_tap_data;
    assign frame_done_o = r_frame_done;
    assign sync_err_o   = r_sync_err;

endmodule
